// File: rtl/pbs_pkg.sv
// Shared battle-system definitions: move encodings and the player-input FSM state type.
package pbs_pkg;

  localparam logic [1:0] MOVE_TACKLE = 2'b00;
  localparam logic [1:0] MOVE_EMBER  = 2'b01;
  localparam logic [1:0] MOVE_SURF   = 2'b10;
  localparam logic [1:0] MOVE_LEECH  = 2'b11;

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    HOLD         = 2'b01,
    WAIT_RELEASE = 2'b10
  } state_t;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser and counter debouncer for an active-low key; emits registered
// press/release pulses one cycle after the debounced level flips, plus the pressed level.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n_i,
  output logic press_o,
  output logic release_o,
  output logic pressed_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             differ, flip;

  always_comb begin
    differ    = (sync2_q != level_q);
    flip      = differ && (cnt_q == CNT_LAST);
    cnt_d     = '0;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (flip) begin
      level_d   = sync2_q;
      press_d   = ~sync2_q;
      release_d = sync2_q;
    end else if (differ) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Reset models a released key so no spurious press follows reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      level_q   <= 1'b1;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= key_n_i;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign press_o   = press_q;
  assign release_o = release_q;
  assign pressed_o = ~level_q;

endmodule

// File: rtl/move_input.sv
// Player input front end: captures the move select on a debounced key press and offers it
// over valid/ready, locking out further presses until consumed and the key is released.
module move_input
  import pbs_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_n,
  input  logic [1:0] move_sel,
  input  logic       enable,
  output logic [1:0] move,
  output logic       move_valid,
  input  logic       move_ready,
  output logic       rejected,
  output logic       pending
);

  logic       press, rel, pressed;
  state_t     state_q, state_d;
  logic [1:0] move_q, move_d;
  logic       rejected_q, rejected_d;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk      (clk),
    .reset_n  (reset_n),
    .key_n_i  (key_n),
    .press_o  (press),
    .release_o(rel),
    .pressed_o(pressed)
  );

  always_comb begin
    state_d    = state_q;
    move_d     = move_q;
    rejected_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (press) begin
          if (enable) begin
            move_d  = move_sel;
            state_d = HOLD;
          end else begin
            rejected_d = 1'b1;
          end
        end
      end
      HOLD: begin
        // A second press can only come from a release/re-press while the move is unclaimed.
        if (press) rejected_d = 1'b1;
        if (move_ready) state_d = pressed ? WAIT_RELEASE : IDLE;
      end
      WAIT_RELEASE: begin
        if (rel) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      move_q     <= MOVE_TACKLE;
      rejected_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      move_q     <= move_d;
      rejected_q <= rejected_d;
    end
  end

  assign move       = move_q;
  assign move_valid = (state_q == HOLD);
  assign pending    = (state_q != IDLE);
  assign rejected   = rejected_q;

endmodule

// File: tb/tb_move_input.sv
// Directed bench for move_input with DEBOUNCE_CYCLES=4: captured moves go through a
// scoreboard queue, latency/pulse/reset behaviour is checked at fixed edges.
module tb_move_input;
  import pbs_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n, key_n, enable, move_ready;
  logic [1:0] move_sel;
  logic [1:0] move;
  logic       move_valid, rejected, pending;

  int total = 0;
  int bad   = 0;
  int rises = 0;
  int r0    = 0;
  logic prev_v = 1'b0;
  logic [1:0] exp_q[$];

  move_input #(.DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .key_n     (key_n),
    .move_sel  (move_sel),
    .enable    (enable),
    .move      (move),
    .move_valid(move_valid),
    .move_ready(move_ready),
    .rejected  (rejected),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pending_low(input string tag, input int limit);
    int n = 0;
    while (pending !== 1'b0 && n < limit) begin
      step();
      n++;
    end
    chk(tag, 32'(pending), 32'd0);
  endtask

  // Scoreboard: a transfer pops the move expected when its press was driven.
  always @(negedge clk) begin
    if (move_valid === 1'b1 && prev_v !== 1'b1) rises++;
    prev_v = move_valid;
    if (reset_n === 1'b1 && move_valid === 1'b1 && move_ready === 1'b1) begin
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("sb_move", 32'(move), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; key_n = 1'b1; enable = 1'b0; move_sel = 2'b00; move_ready = 1'b0;
    #2;
    chk("rst_valid", 32'(move_valid), 32'd0);
    chk("rst_move", 32'(move), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_rejected", 32'(rejected), 32'd0);
    step(); step();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("post_rst_quiet", 32'({move_valid, pending, rejected, move}), 32'd0);
    end

    // Clean press, key held 20 cycles, consumer takes at edge 10.
    step();
    enable = 1'b1; move_sel = MOVE_SURF; key_n = 1'b0; exp_q.push_back(MOVE_SURF); r0 = rises;
    repeat (6) step();
    chk("t1_valid_early", 32'(move_valid), 32'd0);
    step();
    chk("t1_valid", 32'(move_valid), 32'd1);
    chk("t1_move", 32'(move), 32'(MOVE_SURF));
    chk("t1_pending", 32'(pending), 32'd1);
    repeat (3) step();
    move_ready = 1'b1;
    step();
    move_ready = 1'b0;
    chk("t1_valid_drop", 32'(move_valid), 32'd0);
    chk("t1_pending_wr", 32'(pending), 32'd1);
    repeat (9) step();
    key_n = 1'b1;
    repeat (6) step();
    chk("t1_pending_hold", 32'(pending), 32'd1);
    step();
    chk("t1_released", 32'(pending), 32'd0);
    chk("t1_one_valid", 32'(rises - r0), 32'd1);

    // Bouncing key: toggles every 2 cycles for 12 cycles, then settles low.
    step();
    move_sel = MOVE_EMBER; exp_q.push_back(MOVE_EMBER); r0 = rises;
    for (int k = 0; k < 12; k++) begin
      key_n = ((k / 2) % 2 == 0) ? 1'b0 : 1'b1;
      step();
      chk("t2_no_valid_bounce", 32'(move_valid), 32'd0);
    end
    key_n = 1'b0;
    repeat (6) step();
    chk("t2_valid_early", 32'(move_valid), 32'd0);
    step();
    chk("t2_valid", 32'(move_valid), 32'd1);
    chk("t2_move", 32'(move), 32'(MOVE_EMBER));
    move_ready = 1'b1;
    step();
    move_ready = 1'b0;
    chk("t2_valid_drop", 32'(move_valid), 32'd0);
    chk("t2_one_valid", 32'(rises - r0), 32'd1);
    key_n = 1'b1;
    wait_pending_low("t2_release", 20);

    // Press outside the player's turn.
    step();
    enable = 1'b0; move_sel = MOVE_LEECH; key_n = 1'b0; r0 = rises;
    repeat (6) step();
    chk("t3_rej_early", 32'(rejected), 32'd0);
    step();
    chk("t3_rej", 32'(rejected), 32'd1);
    chk("t3_no_valid", 32'(move_valid), 32'd0);
    step();
    chk("t3_rej_once", 32'(rejected), 32'd0);
    chk("t3_move_kept", 32'(move), 32'(MOVE_EMBER));
    chk("t3_idle", 32'(pending), 32'd0);
    key_n = 1'b1;
    repeat (10) step();
    chk("t3_never_valid", 32'(rises - r0), 32'd0);

    // Hold stability, then release and re-press while still unclaimed.
    step();
    enable = 1'b1; move_sel = MOVE_LEECH; key_n = 1'b0; exp_q.push_back(MOVE_LEECH);
    repeat (7) step();
    chk("t4_valid", 32'(move_valid), 32'd1);
    chk("t4_move", 32'(move), 32'(MOVE_LEECH));
    for (int k = 0; k < 4; k++) begin
      move_sel = 2'(k); enable = 1'b0;
      step();
      chk("t4_move_frozen", 32'(move), 32'(MOVE_LEECH));
      chk("t4_valid_held", 32'(move_valid), 32'd1);
    end
    key_n = 1'b1;
    repeat (8) step();
    key_n = 1'b0;
    for (int n = 0; n < 12 && rejected !== 1'b1; n++) step();
    chk("t4_hold_rej", 32'(rejected), 32'd1);
    step();
    chk("t4_hold_rej_once", 32'(rejected), 32'd0);
    chk("t4_valid_after_rej", 32'(move_valid), 32'd1);
    chk("t4_move_after_rej", 32'(move), 32'(MOVE_LEECH));
    move_ready = 1'b1;
    step();
    move_ready = 1'b0;
    chk("t4_valid_drop", 32'(move_valid), 32'd0);
    chk("t4_wait_release", 32'(pending), 32'd1);
    key_n = 1'b1;
    wait_pending_low("t4_release", 20);

    // Consumer ready before valid: one-cycle transfer.
    step();
    enable = 1'b1; move_sel = MOVE_TACKLE; move_ready = 1'b1; key_n = 1'b0;
    exp_q.push_back(MOVE_TACKLE); r0 = rises;
    repeat (6) step();
    chk("t5_valid_early", 32'(move_valid), 32'd0);
    step();
    chk("t5_valid", 32'(move_valid), 32'd1);
    chk("t5_move", 32'(move), 32'(MOVE_TACKLE));
    step();
    move_ready = 1'b0;
    chk("t5_valid_one_cycle", 32'(move_valid), 32'd0);
    chk("t5_pending", 32'(pending), 32'd1);
    chk("t5_one_valid", 32'(rises - r0), 32'd1);
    key_n = 1'b1;
    wait_pending_low("t5_release", 20);

    // Reset while a move is held.
    step();
    enable = 1'b1; move_sel = MOVE_SURF; key_n = 1'b0; exp_q.push_back(MOVE_SURF);
    repeat (7) step();
    chk("t6_valid", 32'(move_valid), 32'd1);
    #2;
    reset_n = 1'b0; key_n = 1'b1;
    #1;
    chk("t6_async_valid", 32'(move_valid), 32'd0);
    chk("t6_async_pending", 32'(pending), 32'd0);
    chk("t6_async_move", 32'(move), 32'd0);
    chk("t6_async_rej", 32'(rejected), 32'd0);
    exp_q.delete();
    #3;
    reset_n = 1'b1;
    r0 = rises;
    repeat (10) step();
    chk("t6_no_valid_after_rst", 32'(rises - r0), 32'd0);
    move_sel = MOVE_EMBER; key_n = 1'b0; exp_q.push_back(MOVE_EMBER);
    repeat (7) step();
    chk("t6_fresh_valid", 32'(move_valid), 32'd1);
    chk("t6_fresh_move", 32'(move), 32'(MOVE_EMBER));
    move_ready = 1'b1;
    step();
    move_ready = 1'b0;
    chk("t6_fresh_drop", 32'(move_valid), 32'd0);
    key_n = 1'b1;
    wait_pending_low("t6_release", 20);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/move_input.md
Name: move_input

Overview:
- Player-side input front end for the battle system. It is the input counterpart of the segment display path: the display presents state to the player, and this block collects the player's move.
- It synchronises and debounces a raw active-low pushbutton, detects a press, and captures the 2-bit move select on that press.
- It offers the captured move to the control FSM over a valid/ready handshake, and locks out repeat presses until the move is consumed and the key is released.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive cycles the synchronised key must differ from the debounced level before that level flips. Minimum 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES)+1: width of the debounce counter. Derived, never overridden.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- key_n  in  1  raw pushbutton, active-low, asynchronous to clk.
- move_sel  in  2  player move switches; sampled only at the capture cycle.
- enable  in  1  high while it is the player's turn; presses outside that window are rejected.
- move  out  2  captured move; stable while move_valid is high.
- move_valid  out  1  captured move available.
- move_ready  in  1  consumer accepts; a transfer happens on any cycle where move_valid and move_ready are both high.
- rejected  out  1  one-cycle pulse when a debounced press is discarded.
- pending  out  1  high in HOLD or WAIT_RELEASE; drives a status LED.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - Both synchroniser flops = 1; debounced level = 1 (released); counter = 0.
  - State = IDLE; move = 0; move_valid = 0; rejected = 0; pending = 0.
- Synchroniser: 2-flop chain on key_n; the debouncer sees only the second flop.
- Debouncer:
  - While the synchronised value differs from the debounced level, the counter increments.
  - Any cycle where they are equal clears the counter.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level takes the synchronised value and the counter clears.
  - press = one-cycle pulse on a debounced 1->0 transition. Debounced 0->1 is "release".
- Latency: if key_n is low and steady from rising edge 0, move_valid is high after edge DEBOUNCE_CYCLES+3 (2 sync + DEBOUNCE_CYCLES debounce + 1 capture).
- FSM states: IDLE, HOLD, WAIT_RELEASE.
- IDLE:
  - press with enable=1: move <= move_sel; go to HOLD; move_valid = 1 from the next cycle.
  - press with enable=0: rejected pulses for 1 cycle; stay in IDLE.
- HOLD:
  - move_valid = 1; move is frozen. move_sel changes and enable deasserting have no effect; no retraction.
  - On transfer: if the key is debounced-pressed, go to WAIT_RELEASE, else go to IDLE. move_valid is 0 from the next cycle.
  - move_ready may be high before move_valid rises; transfer then occurs on the first valid cycle.
  - A new press while in HOLD pulses rejected.
- WAIT_RELEASE:
  - move_valid = 0.
  - On debounced release, go to IDLE.
  - A press cannot occur before release, so none is possible here.
- Simultaneous events: a release in the transfer cycle goes directly to IDLE. A press arriving in the same cycle as the IDLE entry is not captured; it arrives one cycle later at the earliest.
- move holds its last value after transfer until the next capture.
- Reset mid-operation: the pending move is discarded; there is no output glitch beyond the async clear.

Decomposition:
- Shared package pbs_pkg holds:
  - move encoding constants MOVE_TACKLE=2'b00, MOVE_EMBER=2'b01, MOVE_SURF=2'b10, MOVE_LEECH=2'b11;
  - a 2-bit state typedef with IDLE/HOLD/WAIT_RELEASE values.
- Sub-module key_debounce contains the synchroniser, debounce counter and press/release pulse generation. It is parameterised by DEBOUNCE_CYCLES, and move_input instantiates it once.

Test Plan (all with DEBOUNCE_CYCLES=4):
- Reset: reset_n=0 mid-simulation -> move_valid=0, move=0, pending=0, rejected=0 immediately; remain 0 for 10 cycles after release with key_n=1.
- Clean press: enable=1, move_sel=2'b10, key_n low from edge 0 held 20 cycles -> move_valid=1 after edge 7, move=2'b10; move_ready=1 at edge 10 -> move_valid=0 after edge 11, pending=1 until debounced release.
- Bounce: key_n toggles every 2 cycles for 12 cycles then stays low -> exactly one move_valid assertion, starting 7 edges after the final settle.
- Rejected: enable=0, single clean press -> rejected=1 for exactly one cycle, move_valid stays 0, move unchanged.
- Hold stability: in HOLD, toggle move_sel and drop enable -> move constant. move_ready held high before valid -> transfer on first valid cycle, valid high exactly 1 cycle.
- Reset mid-HOLD: assert reset_n=0 while move_valid=1 -> move_valid=0 without waiting for a clk edge; after reset, no move_valid until a fresh press.
